// File: rtl/savomax_sync_gen.sv
// savomax_sync_gen: PAL/NTSC sync timing generator.
//
// Produces active-low HSYNC, VSYNC and composite sync from one clock. Each field
// is a whole number of lines of LINE_CYCLES clocks. The format is latched on
// entry to RUN and re-sampled only at the end of a field, so the output stream
// never changes format mid-field. Outputs are registered one cycle behind the
// pixel/line counters.
//
// Ports:
//   clk_in            clock
//   rst_n_in          synchronous reset, active low
//   enable_in         run request, sampled when idle and at each field end
//   format_in         3'b100 PAL, 3'b010 NTSC, anything else invalid
//   hsync_out         line sync, active low
//   vsync_out         field sync, active low
//   csync_out         composite sync, active low, serrated during VSYNC
//   field_start_out   one-cycle pulse on the first cycle of each field
//   format_active_out format of the field being generated, 3'b000 when idle
//   line_out          current line number (0-based), 0 when idle
module savomax_sync_gen #(
   parameter int unsigned CLK_FREQ    = 250_000,
   parameter int unsigned LINE_CYCLES = 16,
   parameter int unsigned HSYNC_WIDTH = 2,
   parameter int unsigned PAL_LINES   = 313,
   parameter int unsigned NTSC_LINES  = 263,
   parameter int unsigned VSYNC_LINES = 3
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       enable_in,
   input  logic [2:0] format_in,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       csync_out,
   output logic       field_start_out,
   output logic [2:0] format_active_out,
   output logic [8:0] line_out
);

   localparam logic [2:0] FMT_PAL  = 3'b100;
   localparam logic [2:0] FMT_NTSC = 3'b010;
   localparam logic [2:0] FMT_NONE = 3'b000;

   localparam int unsigned MAX_LINES = (PAL_LINES > NTSC_LINES) ? PAL_LINES : NTSC_LINES;
   localparam int unsigned PIX_W     = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
   localparam int unsigned LCNT_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_CYCLES - 1);
   localparam logic [PIX_W-1:0]  HS_WIDTH  = PIX_W'(HSYNC_WIDTH);
   localparam logic [LCNT_W-1:0] VS_LINES  = LCNT_W'(VSYNC_LINES);
   localparam logic [LCNT_W-1:0] PAL_LAST  = LCNT_W'(PAL_LINES - 1);
   localparam logic [LCNT_W-1:0] NTSC_LAST = LCNT_W'(NTSC_LINES - 1);

   // Elaboration-time parameter sanity checks.
   if (CLK_FREQ == 0) begin : g_bad_clk_freq
      $error("CLK_FREQ must be non-zero");
   end
   if (HSYNC_WIDTH < 1 || HSYNC_WIDTH >= LINE_CYCLES) begin : g_bad_hsync_width
      $error("HSYNC_WIDTH must be in 1..LINE_CYCLES-1");
   end
   if (VSYNC_LINES >= NTSC_LINES || VSYNC_LINES >= PAL_LINES) begin : g_bad_vsync_lines
      $error("VSYNC_LINES must be shorter than a field");
   end
   if (MAX_LINES > 512) begin : g_bad_max_lines
      $error("line count does not fit the 9-bit line_out port");
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [2:0]        fmt_q, fmt_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [LCNT_W-1:0] line_q, line_d;

   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       csync_q, csync_d;
   logic       fstart_q, fstart_d;
   logic [2:0] fmt_act_q, fmt_act_d;
   logic [8:0] line_o_q, line_o_d;

   logic              start_ok;
   logic [LCNT_W-1:0] line_last;
   logic              hs_now, vs_now;

   assign start_ok  = enable_in && (format_in == FMT_PAL || format_in == FMT_NTSC);
   assign line_last = (fmt_q == FMT_PAL) ? PAL_LAST : NTSC_LAST;

   // Counter / state next-state logic.
   always_comb begin
      state_d = state_q;
      fmt_d   = fmt_q;
      pix_d   = pix_q;
      line_d  = line_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StRun;
               fmt_d   = format_in;
               pix_d   = '0;
               line_d  = '0;
            end
         end
         StRun: begin
            if (pix_q == PIX_LAST) begin
               pix_d = '0;
               if (line_q == line_last) begin
                  // Field boundary: the only point where format/enable are honoured.
                  line_d = '0;
                  if (start_ok) begin
                     fmt_d = format_in;
                  end else begin
                     state_d = StIdle;
                     fmt_d   = FMT_NONE;
                  end
               end else begin
                  line_d = line_q + 1'b1;
               end
            end else begin
               pix_d = pix_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            fmt_d   = FMT_NONE;
            pix_d   = '0;
            line_d  = '0;
         end
      endcase
   end

   // Output decode from the current counters, registered below.
   always_comb begin
      hs_now    = !(pix_q < HS_WIDTH);
      vs_now    = !(line_q < VS_LINES);
      hsync_d   = 1'b1;
      vsync_d   = 1'b1;
      csync_d   = 1'b1;
      fstart_d  = 1'b0;
      fmt_act_d = FMT_NONE;
      line_o_d  = '0;
      if (state_q == StRun) begin
         hsync_d   = hs_now;
         vsync_d   = vs_now;
         // Inverted line pulses during VSYNC give the serrated composite.
         csync_d   = vs_now ? hs_now : ~hs_now;
         fstart_d  = (line_q == '0) && (pix_q == '0);
         fmt_act_d = fmt_q;
         line_o_d  = 9'(line_q);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q   <= StIdle;
         fmt_q     <= FMT_NONE;
         pix_q     <= '0;
         line_q    <= '0;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         csync_q   <= 1'b1;
         fstart_q  <= 1'b0;
         fmt_act_q <= FMT_NONE;
         line_o_q  <= '0;
      end else begin
         state_q   <= state_d;
         fmt_q     <= fmt_d;
         pix_q     <= pix_d;
         line_q    <= line_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         csync_q   <= csync_d;
         fstart_q  <= fstart_d;
         fmt_act_q <= fmt_act_d;
         line_o_q  <= line_o_d;
      end
   end

   assign hsync_out         = hsync_q;
   assign vsync_out         = vsync_q;
   assign csync_out         = csync_q;
   assign field_start_out   = fstart_q;
   assign format_active_out = fmt_act_q;
   assign line_out          = line_o_q;

endmodule
